// File: rtl/input_debounce_if.sv
// Debouncer signal bundle: raw switch levels in, clean levels and edge pulses out.
// The slave modport is the debouncer; the master modport is the pin driver / consumer side.
interface input_debounce_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] db_out;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;

  modport master (output raw_in, input db_out, input rise_o, input fall_o);
  modport slave  (input raw_in, output db_out, output rise_o, output fall_o);
endinterface

// File: rtl/input_debounce.sv
// Per-bit two-flop synchronizer plus stability-counter debouncer.
// A new synchronized level must persist for CNT_MAX consecutive cycles before
// db_out follows it; any return to the current level clears the count.
// Optional feature macro: INPUT_DEBOUNCE_PULSE_EN builds the rise/fall pulse
// registers; without it rise_o/fall_o are tied low and db_out is unchanged.
module input_debounce #(
  parameter int WIDTH   = 2,
  parameter int CNT_MAX = 1000,
  parameter int CNT_W   = 10
) (
  input logic           clk,
  input logic           rst_n,
  input_debounce_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [WIDTH-1:0] db_reg;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;

  // Two-flop synchronizer on every raw input bit, nothing between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= bus.raw_in;
      s2_reg <= s1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt_reg;
      logic             mismatch;
      logic             accept;

      assign mismatch = (s2_reg[gi] != db_reg[gi]);
      assign accept   = mismatch && (cnt_reg == CNT_LAST);

      // Stability counter: counts consecutive mismatches, accepts on the last one,
      // and restarts from zero whenever the input agrees with the output again.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg    <= '0;
          db_reg[gi] <= 1'b0;
        end else if (!mismatch) begin
          cnt_reg <= '0;
        end else if (accept) begin
          cnt_reg    <= '0;
          db_reg[gi] <= s2_reg[gi];
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

`ifdef INPUT_DEBOUNCE_PULSE_EN
      // Edge pulses registered on the same edge that updates db_out, so each is
      // high for exactly the following cycle and the two are mutually exclusive.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rise_reg[gi] <= 1'b0;
          fall_reg[gi] <= 1'b0;
        end else begin
          rise_reg[gi] <= accept &  s2_reg[gi];
          fall_reg[gi] <= accept & ~s2_reg[gi];
        end
      end
`else
      assign rise_reg[gi] = 1'b0;
      assign fall_reg[gi] = 1'b0;
`endif
    end
  endgenerate

  assign bus.db_out = db_reg;
  assign bus.rise_o = rise_reg;
  assign bus.fall_o = fall_reg;

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce (WIDTH=2, CNT_MAX=4, CNT_W=3).
// The reference model accepts a new level once the synchronized input (raw
// sampled two edges earlier) has differed from the output on CNT_MAX
// consecutive edges since the last output change or reset.
module tb_input_debounce;

  localparam int WIDTH   = 2;
  localparam int CNT_MAX = 4;
  localparam int CNT_W   = 3;
`ifdef INPUT_DEBOUNCE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  input_debounce_if #(.WIDTH(WIDTH)) bus ();

  input_debounce #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [WIDTH-1:0] hist [0:8191];
  int               e = 0;
  int               base = 0;
  int               last_chg [WIDTH];
  logic             rst_active = 1'b1;
  logic [WIDTH-1:0] exp_db = '0;
  logic [WIDTH-1:0] exp_rise = '0;
  logic [WIDTH-1:0] exp_fall = '0;

  function automatic logic [WIDTH-1:0] pr();
    return PULSE_EN ? exp_rise : '0;
  endfunction
  function automatic logic [WIDTH-1:0] pf();
    return PULSE_EN ? exp_fall : '0;
  endfunction

  function automatic logic samp(int idx, int i);
    if (idx <= base) return 1'b0;
    return hist[idx][i];
  endfunction

  // Advance one clock edge and update the model; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    e++;
    hist[e] = bus.raw_in;
    exp_rise = '0;
    exp_fall = '0;
    if (rst_active) begin
      base = e;
      for (int i = 0; i < WIDTH; i++) last_chg[i] = e;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (e - CNT_MAX + 1 > last_chg[i]) begin
          bit ok;
          ok = 1'b1;
          for (int k = e - CNT_MAX + 1; k <= e; k++)
            if (samp(k - 2, i) == exp_db[i]) ok = 1'b0;
          if (ok) begin
            exp_db[i]   = ~exp_db[i];
            last_chg[i] = e;
            if (exp_db[i]) exp_rise[i] = 1'b1;
            else           exp_fall[i] = 1'b1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic assert_reset();
    rst_n      = 1'b0;
    rst_active = 1'b1;
    exp_db     = '0;
    exp_rise   = '0;
    exp_fall   = '0;
    base       = e;
    for (int i = 0; i < WIDTH; i++) last_chg[i] = e;
  endtask

  task automatic release_reset();
    rst_n      = 1'b1;
    rst_active = 1'b0;
  endtask

  task automatic test_reset();
    bus.raw_in = '0;
    assert_reset();
    #1;
    n_checks++;
    if (bus.db_out !== 2'b00 || bus.rise_o !== 2'b00 || bus.fall_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_init db=%b rise=%b fall=%b required 00/00/00", bus.db_out, bus.rise_o, bus.fall_o);
    end
    tick(); tick();
    release_reset();
    for (int n = 0; n < 4; n++) begin
      tick();
      n_checks++;
      if (bus.db_out !== 2'b00 || bus.rise_o !== 2'b00 || bus.fall_o !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_idle n=%0d db=%b rise=%b fall=%b required 00/00/00", n, bus.db_out, bus.rise_o, bus.fall_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.raw_in = 2'b01;
    for (int n = 1; n <= 4; n++) tick();   // counter for bit 0 now at 2
    #2;
    bus.raw_in = 2'b00;
    assert_reset();
    #1;
    n_checks++;
    if (bus.db_out !== 2'b00 || bus.rise_o !== 2'b00 || bus.fall_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_async db=%b rise=%b fall=%b required 00/00/00", bus.db_out, bus.rise_o, bus.fall_o);
    end
    tick(); tick();
    release_reset();
    for (int n = 1; n <= 8; n++) begin
      tick();
      n_checks++;
      if (bus.db_out !== 2'b00 || bus.rise_o !== 2'b00 || bus.fall_o !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_mid_after n=%0d db=%b rise=%b fall=%b required 00/00/00", n, bus.db_out, bus.rise_o, bus.fall_o);
      end
    end
  endtask

  task automatic test_clean_step();
    bus.raw_in = 2'b01;
    for (int n = 1; n <= 8; n++) begin
      tick();
      n_checks++;
      if (bus.db_out !== exp_db || bus.rise_o !== pr() || bus.fall_o !== pf()) begin
        n_fail++;
        $display("FAIL step_model edge=%0d db=%b/%b rise=%b/%b fall=%b/%b (got/required)",
                 n, bus.db_out, exp_db, bus.rise_o, pr(), bus.fall_o, pf());
      end
      if (n == 5 || n == 6 || n == 7) begin
        n_checks++;
        if (bus.db_out !== ((n == 5) ? 2'b00 : 2'b01) ||
            bus.rise_o !== ((n == 6 && PULSE_EN) ? 2'b01 : 2'b00) || bus.fall_o !== 2'b00) begin
          n_fail++;
          $display("FAIL step_timing edge=%0d db=%b rise=%b fall=%b", n, bus.db_out, bus.rise_o, bus.fall_o);
        end
      end
    end
  endtask

  task automatic test_glitch();
    // Precondition: db_out = 00 and idle
    for (int n = 1; n <= 10; n++) begin
      bus.raw_in = (n <= 3) ? 2'b01 : 2'b00;
      tick();
      n_checks++;
      if (bus.db_out !== 2'b00 || bus.rise_o !== 2'b00 || bus.fall_o !== 2'b00 || exp_db !== 2'b00) begin
        n_fail++;
        $display("FAIL glitch edge=%0d db=%b rise=%b fall=%b required 00/00/00", n, bus.db_out, bus.rise_o, bus.fall_o);
      end
    end
  endtask

  task automatic test_independent();
    for (int n = 1; n <= 10; n++) begin
      bus.raw_in = (n >= 3) ? 2'b11 : 2'b01;
      tick();
      n_checks++;
      if (bus.db_out !== exp_db || bus.rise_o !== pr() || bus.fall_o !== pf()) begin
        n_fail++;
        $display("FAIL indep_model edge=%0d db=%b/%b rise=%b/%b fall=%b/%b (got/required)",
                 n, bus.db_out, exp_db, bus.rise_o, pr(), bus.fall_o, pf());
      end
      if (n == 6 || n == 8) begin
        n_checks++;
        if (bus.db_out !== ((n == 6) ? 2'b01 : 2'b11) ||
            bus.rise_o !== (PULSE_EN ? ((n == 6) ? 2'b01 : 2'b10) : 2'b00)) begin
          n_fail++;
          $display("FAIL indep_timing edge=%0d db=%b rise=%b", n, bus.db_out, bus.rise_o);
        end
      end
    end
  endtask

  task automatic test_release();
    // Precondition: db_out = 11 and idle
    bus.raw_in = 2'b00;
    for (int n = 1; n <= 8; n++) begin
      tick();
      n_checks++;
      if (bus.db_out !== exp_db || bus.rise_o !== pr() || bus.fall_o !== pf()) begin
        n_fail++;
        $display("FAIL release_model edge=%0d db=%b/%b rise=%b/%b fall=%b/%b (got/required)",
                 n, bus.db_out, exp_db, bus.rise_o, pr(), bus.fall_o, pf());
      end
      if (n == 5 || n == 6 || n == 7) begin
        n_checks++;
        if (bus.db_out !== ((n == 5) ? 2'b11 : 2'b00) ||
            bus.fall_o !== ((n == 6 && PULSE_EN) ? 2'b11 : 2'b00) || bus.rise_o !== 2'b00) begin
          n_fail++;
          $display("FAIL release_timing edge=%0d db=%b rise=%b fall=%b", n, bus.db_out, bus.rise_o, bus.fall_o);
        end
      end
    end
  endtask

  task automatic test_random();
    int hold [WIDTH];
    for (int i = 0; i < WIDTH; i++) hold[i] = $urandom_range(1, 8);
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < WIDTH; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          bus.raw_in[i] = ~bus.raw_in[i];
          hold[i] = $urandom_range(1, 8);
        end
      end
      if (!rst_active && $urandom_range(0, 299) == 0) begin
        #2;
        assert_reset();
        #1;
        n_checks++;
        if (bus.db_out !== 2'b00 || bus.rise_o !== 2'b00 || bus.fall_o !== 2'b00) begin
          n_fail++;
          $display("FAIL rand_reset n=%0d db=%b rise=%b fall=%b required 00/00/00", n, bus.db_out, bus.rise_o, bus.fall_o);
        end
      end else if (rst_active) begin
        release_reset();
      end
      tick();
      n_checks++;
      if (bus.db_out !== exp_db || bus.rise_o !== pr() || bus.fall_o !== pf() ||
          (bus.rise_o & bus.fall_o) !== 2'b00) begin
        n_fail++;
        $display("FAIL random n=%0d raw=%b db=%b/%b rise=%b/%b fall=%b/%b (got/required)",
                 n, bus.raw_in, bus.db_out, exp_db, bus.rise_o, pr(), bus.fall_o, pf());
      end
    end
    if (rst_active) release_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.raw_in = '0;
    for (int i = 0; i < WIDTH; i++) last_chg[i] = 0;
    test_reset();
    test_reset_mid();
    test_clean_step();      // db -> 01
    bus.raw_in = 2'b00;
    for (int n = 0; n < 8; n++) tick();  // back to 00, idle
    test_glitch();
    test_clean_step();      // no partial credit from the glitch: same timing
    bus.raw_in = 2'b00;
    for (int n = 0; n < 8; n++) tick();
    test_independent();     // db -> 11
    for (int n = 0; n < 4; n++) tick();
    test_release();         // db -> 00
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
